// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared FSM state and access size encodings for the LSU APB bridge
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SIZE_B   = 2'd0;
    localparam logic [1:0] SIZE_H   = 2'd1;
    localparam logic [1:0] SIZE_W   = 2'd2;
    localparam logic [1:0] SIZE_ILL = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane shift, strobe, alignment check and load extension
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  req_addr_lo,
    input  logic [1:0]  req_size,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    output logic [31:0] wdata_shifted,
    output logic [3:0]  wstrb,
    output logic        misaligned,
    output logic        illegal,
    input  logic [1:0]  rsp_addr_lo,
    input  logic [1:0]  rsp_size,
    input  logic        rsp_unsigned,
    input  logic [31:0] prdata,
    output logic [31:0] rdata_ext
);

    logic [31:0] rshift;
    logic        sign_fill;

    always_comb begin
        wdata_shifted = req_wdata << {req_addr_lo, 3'b000};
        wstrb         = 4'b0000;
        if (req_write) begin
            case (req_size)
                SIZE_B:  wstrb = 4'b0001 << req_addr_lo;
                SIZE_H:  wstrb = 4'b0011 << req_addr_lo;
                SIZE_W:  wstrb = 4'b1111;
                default: wstrb = 4'b0000;
            endcase
        end
        misaligned = ((req_size == SIZE_H) && req_addr_lo[0]) ||
                     ((req_size == SIZE_W) && (req_addr_lo != 2'b00));
        illegal    = (req_size == SIZE_ILL);
    end

    // Load lanes come back at their byte offset; bring them down to bit 0 before extending.
    always_comb begin
        rshift    = prdata >> {rsp_addr_lo, 3'b000};
        sign_fill = 1'b0;
        rdata_ext = rshift;
        case (rsp_size)
            SIZE_B: begin
                sign_fill = ~rsp_unsigned & rshift[7];
                rdata_ext = {{24{sign_fill}}, rshift[7:0]};
            end
            SIZE_H: begin
                sign_fill = ~rsp_unsigned & rshift[15];
                rdata_ext = {{16{sign_fill}}, rshift[15:0]};
            end
            default: rdata_ext = rshift;
        endcase
    end

endmodule

// File: rtl/lsu_apb_master.sv
// rtl/lsu_apb_master.sv - core load/store request to APB master bridge
module lsu_apb_master
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_misaligned,
    output logic        apb_psel,
    output logic        apb_penable,
    output logic        apb_pwrite,
    output logic [31:0] apb_paddr,
    output logic [31:0] apb_pwdata,
    output logic [3:0]  apb_pwstrb,
    input  logic        apb_pready,
    input  logic        apb_pslverr,
    input  logic [31:0] apb_prdata
);

    lsu_state_e  state, state_next;

    logic [31:0] addr_q;
    logic [31:0] pwdata_q;
    logic [3:0]  pwstrb_q;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        mis_q;

    logic [31:0] wdata_shifted;
    logic [3:0]  wstrb;
    logic        misaligned;
    logic        illegal;
    logic [31:0] rdata_ext;
    logic        req_fire;

    lsu_align u_align (
        .req_addr_lo   (req_addr[1:0]),
        .req_size      (req_size),
        .req_write     (req_write),
        .req_wdata     (req_wdata),
        .wdata_shifted (wdata_shifted),
        .wstrb         (wstrb),
        .misaligned    (misaligned),
        .illegal       (illegal),
        .rsp_addr_lo   (addr_q[1:0]),
        .rsp_size      (size_q),
        .rsp_unsigned  (unsigned_q),
        .prdata        (apb_prdata),
        .rdata_ext     (rdata_ext)
    );

    assign req_ready = (state == ST_IDLE);
    assign req_fire  = req_valid & req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_fire) state_next = (misaligned | illegal) ? ST_RESP : ST_SETUP;
            end
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: if (apb_pready) state_next = ST_RESP;
            ST_RESP:   if (rsp_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Rejected requests never touch the APB-side registers, so the bus keeps its last values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            pwdata_q   <= '0;
            pwstrb_q   <= '0;
            write_q    <= 1'b0;
            size_q     <= SIZE_B;
            unsigned_q <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            mis_q      <= 1'b0;
        end else if (state == ST_IDLE && req_fire) begin
            if (misaligned | illegal) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
                mis_q   <= misaligned;
            end else begin
                addr_q     <= req_addr;
                pwdata_q   <= wdata_shifted;
                pwstrb_q   <= wstrb;
                write_q    <= req_write;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                rdata_q    <= '0;
                err_q      <= 1'b0;
                mis_q      <= 1'b0;
            end
        end else if (state == ST_ACCESS && apb_pready) begin
            rdata_q <= (apb_pslverr | write_q) ? 32'h0 : rdata_ext;
            err_q   <= apb_pslverr;
            mis_q   <= 1'b0;
        end
    end

    assign apb_psel       = (state == ST_SETUP) || (state == ST_ACCESS);
    assign apb_penable    = (state == ST_ACCESS);
    assign apb_pwrite     = write_q;
    assign apb_paddr      = addr_q;
    assign apb_pwdata     = pwdata_q;
    assign apb_pwstrb     = pwstrb_q;
    assign rsp_valid      = (state == ST_RESP);
    assign rsp_rdata      = rdata_q;
    assign rsp_err        = err_q;
    assign rsp_misaligned = mis_q;

endmodule

// File: doc/lsu_apb_master.md
LSU_APB_MASTER -- requirements
Module: lsu_apb_master

Interface
REQ-001 Parameters SHALL be none; address and data are fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  core load/store request valid.
REQ-005 req_ready  out  1  bridge accepts request; handshake on req_valid & req_ready.
REQ-006 req_addr  in  32  byte address.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-009 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_wdata  in  32  store data, LSB-aligned.
REQ-011 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-012 rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 rsp_err  out  1  bus error, misalignment or illegal size.
REQ-014 rsp_misaligned  out  1  error caused by misalignment.
REQ-015 apb_psel, apb_penable, apb_pwrite  out  1 each  APB control to the fabric.
REQ-016 apb_paddr, apb_pwdata  out  32 each  APB address and lane-shifted write data.
REQ-017 apb_pwstrb  out  4  byte strobes; 0 for reads.
REQ-018 apb_pready, apb_pslverr  in  1 each, apb_prdata  in  32  APB response.

Function
REQ-019 FSM states SHALL be IDLE, SETUP, ACCESS and RESP; req_ready = (state == IDLE).
REQ-020 IDLE: on an accepted legal request, latch addr, write, size, unsigned and shifted wdata, then go to SETUP.
REQ-021 Misalignment: half with addr[0]=1, or word with addr[1:0]!=0; illegal size: size=3.
REQ-022 IDLE: on an accepted misaligned or illegal request, go directly to RESP with rsp_err=1, no psel, and rsp_misaligned=1 only for misalignment.
REQ-023 SETUP: psel=1, penable=0, then go to ACCESS unconditionally.
REQ-024 ACCESS: psel=1, penable=1; stay while pready=0; on pready=1 capture prdata and pslverr, then go to RESP.
REQ-025 paddr, pwrite, pwdata and pwstrb SHALL be stable from SETUP through the last ACCESS cycle.
REQ-026 pwdata = wdata << (8*addr[1:0]).
REQ-027 pwstrb: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111; read = 4'b0000.
REQ-028 paddr SHALL be the full request address, not word-aligned.
REQ-029 Load data = prdata >> (8*addr[1:0]), truncated to size, then zero- or sign-extended per req_unsigned.
REQ-030 RESP: rsp_valid=1 and outputs held stable until rsp_ready=1, then go to IDLE.
REQ-031 Minimum legal transaction: accept, SETUP, ACCESS, RESP, i.e. rsp_valid three cycles after acceptance with pready=1.
REQ-032 Back-to-back: no new request is accepted in the RESP cycle; the next acceptance occurs in IDLE.
REQ-033 pslverr=1 SHALL give rsp_err=1 and rsp_rdata=0; rsp_misaligned=0.

Reset
REQ-034 While rst=1: state=IDLE; psel, penable, pwrite and rsp_valid = 0.
REQ-035 While rst=1: rsp_err and rsp_misaligned = 0; paddr, pwdata, rsp_rdata = 0; pwstrb = 0.
REQ-036 Reset asserted mid-transaction SHALL drop psel and penable immediately and discard the in-flight response.

Structure
REQ-037 A shared package lsu_pkg SHALL hold the FSM state enum and the size encodings (SIZE_B, SIZE_H, SIZE_W).
REQ-038 Shift, strobe and extend logic SHALL live in one combinational sub-module lsu_align.
REQ-039 Only the FSM and capture registers SHALL live in lsu_apb_master.

Verification
REQ-040 Word store at 0x8000_0004 with wdata 0xDEADBEEF and pready=1: SETUP then ACCESS, paddr 0x8000_0004, pwstrb 4'hF; rsp_valid after 3 cycles, rsp_err=0.
REQ-041 Signed byte load at 0x0000_0003 with prdata 0x80xx_xxxx: rsp_rdata 0xFFFF_FF80; unsigned gives 0x0000_0080.
REQ-042 Half store at 0x0000_0002 with wdata 0x1234: pwdata 0x1234_0000, pwstrb 4'b1100.
REQ-043 Word load at 0x0000_0002: no psel, rsp_err=1, rsp_misaligned=1 one cycle after acceptance; size=3 gives rsp_err=1, rsp_misaligned=0.
REQ-044 Slave with pready low for 4 cycles then pslverr=1: ACCESS held 5 cycles with stable signals; rsp_err=1, rsp_rdata=0.
REQ-045 rst asserted during ACCESS: psel=0 immediately; after release, req_ready=1 and no rsp_valid.
